decode_ctrl: RTL and testbench

Decode-stage controller for the 5-stage RISC-V pipeline. It owns the IF/ID pipeline register and decodes the held opcode into the 3-bit immediate-format select and the 25-bit instruction field that feed the immediate sign-extender. It also detects load-use hazards, inserts bubbles, handles flush from EX, and applies valid/ready handshakes to IF (upstream) and ID/EX (downstream).

---
 rtl/decode_ctrl_pkg.sv | 29 ++
 rtl/decode_ctrl_if.sv | 29 ++
 rtl/decode_ctrl_opcode_decoder.sv | 44 ++++
 rtl/decode_ctrl.sv | 119 +++++++++++
 tb/tb_decode_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_ctrl_pkg.sv
// Shared decode definitions: opcode constants, immediate-format encodings
// (also consumed by the sign-extender) and the decode-stage FSM states.
package decode_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    HAZ   = 2'b10
  } dstate_e;

endpackage

// File: rtl/decode_ctrl_if.sv
// Fetch-side and ID/EX-side handshake bundle of the decode stage.
// master = surrounding pipeline, slave = decode_ctrl.
interface decode_ctrl_if #(parameter int XLEN = 32);
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;
  logic            ex_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [24:0]     imm_in;
  logic [2:0]      imm_src;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            illegal;

  modport master (
    output if_valid, if_instr, if_pc, ex_ready,
    input  id_ready, id_valid, id_pc, imm_in, imm_src,
           id_rs1, id_rs2, id_rd, illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready,
    output id_ready, id_valid, id_pc, imm_in, imm_src,
           id_rs1, id_rs2, id_rd, illegal
  );
endinterface

// File: rtl/decode_ctrl_opcode_decoder.sv
// Combinational opcode classifier: immediate format, source-register usage
// and illegal-opcode flag (ungated; the caller qualifies it with occupancy).
module opcode_decoder
  import decode_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_src,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       illegal
);

  always_comb begin
    imm_src  = IMM_I;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm_src  = IMM_I;
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        imm_src  = IMM_S;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm_src  = IMM_B;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_JAL:          imm_src = IMM_J;
      OP_LUI, OP_AUIPC: imm_src = IMM_U;
      // R-type has no immediate; the default format I is left unchanged
      OP_REG: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: IF/ID register, immediate-format decode, load-use
// bubble insertion and flush. Optional counters under DECODE_CTRL_PERF_EN.
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_ctrl_if.slave      bus,
  input  logic              flush,
  input  logic              idex_mem_read,
  input  logic [4:0]        idex_rd,
  output logic              load_use_stall,
  output logic [1:0]        state,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  dstate_e         state_p1, state_nx;
  logic [XLEN-1:0] instr_p1;
  logic [XLEN-1:0] pc_p1;

  logic       full, hazard, fire, capture, ready;
  logic [2:0] imm_src_d;
  logic       uses_rs1, uses_rs2, illegal_d;
  logic [4:0] rs1, rs2;

  opcode_decoder u_dec (
    .opcode   (instr_p1[6:0]),
    .imm_src  (imm_src_d),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .illegal  (illegal_d)
  );

  assign full = (state_p1 != EMPTY);
  assign rs1  = instr_p1[19:15];
  assign rs2  = instr_p1[24:20];

  assign hazard = full & idex_mem_read & (idex_rd != 5'd0) &
                  ((uses_rs1 & (rs1 == idex_rd)) | (uses_rs2 & (rs2 == idex_rd)));

  assign load_use_stall = hazard & ~flush;
  assign bus.id_valid   = full & ~hazard & ~flush;
  assign fire           = bus.id_valid & bus.ex_ready;
  assign ready          = ~full | fire | flush;
  assign capture        = bus.if_valid & ready & ~flush;

  // A stall that clears leaves the same instruction to be issued, so HAZ
  // then follows the FULL rules; otherwise a fired instruction would linger.
  always_comb begin
    state_nx = state_p1;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state_p1)
        EMPTY:     if (capture) state_nx = FULL;
        FULL, HAZ: begin
          if (hazard)    state_nx = HAZ;
          else if (fire) state_nx = capture ? FULL : EMPTY;
          else           state_nx = FULL;
        end
        default:   state_nx = EMPTY;
      endcase
    end
  end

  // ---- IF/ID register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
      instr_p1 <= XLEN'(NOP_INSTR);
      pc_p1    <= '0;
    end else begin
      state_p1 <= state_nx;
      if (capture) begin
        instr_p1 <= bus.if_instr;
        pc_p1    <= bus.if_pc;
      end
    end
  end

  assign bus.id_ready = ready;
  assign bus.id_pc    = pc_p1;
  assign bus.imm_in   = instr_p1[31:7];
  assign bus.imm_src  = imm_src_d;
  assign bus.id_rs1   = rs1;
  assign bus.id_rs2   = rs2;
  assign bus.id_rd    = instr_p1[11:7];
  assign bus.illegal  = full & illegal_d;
  assign state        = state_p1;

`ifdef DECODE_CTRL_PERF_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  logic [PERF_W-1:0] stall_cnt_p1, flush_cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_p1 <= '0;
      flush_cnt_p1 <= '0;
    end else begin
      if (load_use_stall) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      if (flush)          flush_cnt_p1 <= sat_inc(flush_cnt_p1);
    end
  end

  assign perf_stall_cnt = stall_cnt_p1;
  assign perf_flush_cnt = flush_cnt_p1;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: directed vector table, hand sequences
// and randomized traffic against a one-slot behavioural model.
module tb_decode_ctrl;
  import decode_pkg::*;

  localparam int XLEN   = 32;
  localparam int PERF_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              idex_mem_read = 1'b0;
  logic [4:0]        idex_rd = 5'd0;
  logic              load_use_stall;
  logic [1:0]        state;
  logic [PERF_W-1:0] perf_stall_cnt, perf_flush_cnt;

  decode_ctrl_if #(.XLEN(XLEN)) bus ();

  decode_ctrl #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .flush          (flush),
    .idex_mem_read  (idex_mem_read),
    .idex_rd        (idex_rd),
    .load_use_stall (load_use_stall),
    .state          (state),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the IF/ID slot holds at most one instruction.
  bit          m_full, m_stalled;
  logic [31:0] m_instr, m_pc;
  longint      m_sc, m_fc;
  localparam longint PERF_MAX = (64'd1 << PERF_W) - 1;

  function automatic void ref_decode(input logic [6:0] op, output logic [2:0] fmt,
                                     output bit u1, output bit u2, output bit legal);
    fmt = 3'd0; u1 = 0; u2 = 0; legal = 1;
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111: u1 = 1;
      7'b0100011: begin fmt = 3'd1; u1 = 1; u2 = 1; end
      7'b1100011: begin fmt = 3'd2; u1 = 1; u2 = 1; end
      7'b1101111: fmt = 3'd3;
      7'b0110111, 7'b0010111: fmt = 3'd4;
      7'b0110011: begin u1 = 1; u2 = 1; end
      default: legal = 0;
    endcase
  endfunction

  task automatic model_reset();
    m_full = 0; m_stalled = 0; m_instr = 32'h13; m_pc = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit fl, input bit mr, input logic [4:0] rd, input bit er);
    bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc;
    flush = fl; idex_mem_read = mr; idex_rd = rd; bus.ex_ready = er;
    #1;
  endtask

  // Compare every output with the model for the current cycle, then advance.
  task automatic tick();
    logic [2:0] fmt;
    bit u1, u2, legal, haz, e_valid, e_stall, e_ready, take;
    logic [1:0] e_state;
    ref_decode(m_instr[6:0], fmt, u1, u2, legal);
    haz = m_full && idex_mem_read && (idex_rd != 0) &&
          ((u1 && m_instr[19:15] == idex_rd) || (u2 && m_instr[24:20] == idex_rd));
    e_stall = haz && !flush;
    e_valid = m_full && !haz && !flush;
    e_ready = !m_full || (e_valid && bus.ex_ready) || flush;
    e_state = !m_full ? EMPTY : (m_stalled ? HAZ : FULL);
    check("id_valid", 64'(bus.id_valid), 64'(e_valid));
    check("id_ready", 64'(bus.id_ready), 64'(e_ready));
    check("load_use_stall", 64'(load_use_stall), 64'(e_stall));
    check("illegal", 64'(bus.illegal), 64'(m_full && !legal));
    check("imm_src", 64'(bus.imm_src), 64'(fmt));
    check("imm_in", 64'(bus.imm_in), 64'(m_instr >> 7));
    check("id_pc", 64'(bus.id_pc), 64'(m_pc));
    check("id_rs1", 64'(bus.id_rs1), 64'(m_instr[19:15]));
    check("id_rs2", 64'(bus.id_rs2), 64'(m_instr[24:20]));
    check("id_rd", 64'(bus.id_rd), 64'(m_instr[11:7]));
    check("state", 64'(state), 64'(e_state));
`ifdef DECODE_CTRL_PERF_EN
    check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_sc));
    check("perf_flush_cnt", 64'(perf_flush_cnt), 64'(m_fc));
`else
    check("perf_stall_cnt", 64'(perf_stall_cnt), 64'd0);
    check("perf_flush_cnt", 64'(perf_flush_cnt), 64'd0);
`endif
    take = bus.if_valid && e_ready && !flush;
    if (flush) m_full = 0;
    else if (take) begin m_full = 1; m_instr = bus.if_instr; m_pc = bus.if_pc; end
    else if (e_valid && bus.ex_ready) m_full = 0;
    m_stalled = e_stall;
    if (e_stall && m_sc < PERF_MAX) m_sc++;
    if (flush && m_fc < PERF_MAX) m_fc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
    rst_n = 1'b0;
    #1;
    check("rst id_valid", 64'(bus.id_valid), 64'd0);
    check("rst id_ready", 64'(bus.id_ready), 64'd1);
    check("rst state", 64'(state), 64'd0);
    check("rst imm_src", 64'(bus.imm_src), 64'd0);
    check("rst illegal", 64'(bus.illegal), 64'd0);
    check("rst stall", 64'(load_use_stall), 64'd0);
    check("rst id_pc", 64'(bus.id_pc), 64'd0);
    check("rst imm_in", 64'(bus.imm_in), 64'd0);
    check("rst perf_stall", 64'(perf_stall_cnt), 64'd0);
    check("rst perf_flush", 64'(perf_flush_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] instr;
    bit          mr;
    logic [4:0]  rd;
    logic [2:0]  src;
    bit          ill;
    bit          stall;
  } vec_t;

  vec_t vecs[$];
  logic [6:0] ops [12] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                           7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111,
                           7'b0110011, 7'b0110011, 7'b1111111, 7'b0001011};

  initial begin
    bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0; bus.ex_ready = 0;
    @(negedge clk);
    do_reset();

    // addi x1,x0,5 then held under backpressure
    drive(1, 32'h0050_0093, 32'h100, 0, 0, 5'd0, 1); tick();
    drive(0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
    check("addi id_valid", 64'(bus.id_valid), 64'd1);
    check("addi imm_in", 64'(bus.imm_in), 64'h000A001);
    check("addi id_rd", 64'(bus.id_rd), 64'd1);
    check("addi state", 64'(state), 64'(FULL));
    tick();

    // add x3,x1,x2 against a load into x1: two stall cycles, then release
    drive(1, 32'h0020_81B3, 32'h104, 0, 0, 5'd0, 1); tick();
    drive(1, 32'h0000_0013, 32'h108, 0, 1, 5'd1, 1);
    check("lu stall", 64'(load_use_stall), 64'd1);
    check("lu id_valid", 64'(bus.id_valid), 64'd0);
    check("lu id_ready", 64'(bus.id_ready), 64'd0);
    tick();
    drive(1, 32'h0000_0013, 32'h108, 0, 1, 5'd1, 1);
    check("lu state haz", 64'(state), 64'(HAZ));
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 5'd1, 0);
    check("lu clear id_valid", 64'(bus.id_valid), 64'd1);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
    check("lu clear state", 64'(state), 64'(FULL));
    tick();

    // jal has no source registers: no stall even with matching fields
    drive(1, 32'h0000_80EF, 32'h10C, 0, 0, 5'd0, 1); tick();
    drive(0, 32'h0, 32'h0, 0, 1, 5'd1, 0);
    check("jal stall", 64'(load_use_stall), 64'd0);
    check("jal id_valid", 64'(bus.id_valid), 64'd1);
    check("jal imm_src", 64'(bus.imm_src), 64'(IMM_J));
    tick();

    // flush discards the held jal and the incoming sw
    drive(1, 32'h0011_2023, 32'h110, 1, 0, 5'd0, 1);
    check("flush id_valid", 64'(bus.id_valid), 64'd0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 5'd0, 1);
    check("flush state", 64'(state), 64'(EMPTY));
    check("flush id_valid next", 64'(bus.id_valid), 64'd0);
    tick();

    // lui under 3 cycles of backpressure, released on the 4th
    drive(1, 32'h1234_50B7, 32'h200, 0, 0, 5'd0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0000_0013, 32'h204, 0, 0, 5'd0, 0);
      check("bp id_ready", 64'(bus.id_ready), 64'd0);
      check("bp imm_src", 64'(bus.imm_src), 64'(IMM_U));
      check("bp imm_in", 64'(bus.imm_in), 64'h0246_8A1);
      check("bp id_pc", 64'(bus.id_pc), 64'h200);
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 0, 5'd0, 1);
    check("bp release valid", 64'(bus.id_valid), 64'd1);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 5'd0, 1);
    check("bp release state", 64'(state), 64'(EMPTY));
    tick();

    // illegal opcode still issues
    drive(1, 32'h0000_007F, 32'h300, 0, 0, 5'd0, 1); tick();
    drive(0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
    check("ill illegal", 64'(bus.illegal), 64'd1);
    check("ill id_valid", 64'(bus.id_valid), 64'd1);
    tick();

    // counters from a clean reset: 2 stalls then 1 flush
    do_reset();
    drive(1, 32'h0020_81B3, 32'h400, 0, 0, 5'd0, 1); tick();
    drive(0, 32'h0, 32'h0, 0, 1, 5'd2, 1); tick();
    drive(0, 32'h0, 32'h0, 0, 1, 5'd2, 1); tick();
    drive(0, 32'h0, 32'h0, 1, 1, 5'd2, 1); tick();
    drive(0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
`ifdef DECODE_CTRL_PERF_EN
    check("perf stall 2", 64'(perf_stall_cnt), 64'd2);
    check("perf flush 1", 64'(perf_flush_cnt), 64'd1);
`else
    check("perf stall tied", 64'(perf_stall_cnt), 64'd0);
    check("perf flush tied", 64'(perf_flush_cnt), 64'd0);
`endif
    tick();

    // directed vector table: decode and hazard per instruction class
    vecs.push_back('{32'h0050_0093, 1'b1, 5'd0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{32'h0020_81B3, 1'b1, 5'd2, 3'd0, 1'b0, 1'b1});
    vecs.push_back('{32'h0020_81B3, 1'b1, 5'd0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{32'h0020_81B3, 1'b0, 5'd1, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{32'h0011_2023, 1'b1, 5'd1, 3'd1, 1'b0, 1'b1});
    vecs.push_back('{32'h0020_8063, 1'b1, 5'd2, 3'd2, 1'b0, 1'b1});
    vecs.push_back('{32'h0000_80EF, 1'b1, 5'd1, 3'd3, 1'b0, 1'b0});
    vecs.push_back('{32'h1234_50B7, 1'b1, 5'd8, 3'd4, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0097, 1'b1, 5'd1, 3'd4, 1'b0, 1'b0});
    vecs.push_back('{32'h0004_2283, 1'b1, 5'd8, 3'd0, 1'b0, 1'b1});
    vecs.push_back('{32'h0000_8067, 1'b1, 5'd1, 3'd0, 1'b0, 1'b1});
    vecs.push_back('{32'h0000_007F, 1'b1, 5'd0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{32'h0010_807F, 1'b1, 5'd1, 3'd0, 1'b1, 1'b0});
    foreach (vecs[k]) begin
      drive(0, 32'h0, 32'h0, 1, 0, 5'd0, 0); tick();
      drive(1, vecs[k].instr, 32'h1000 + 32'(k * 4), 0, 0, 5'd0, 1); tick();
      drive(0, 32'h0, 32'h0, 0, vecs[k].mr, vecs[k].rd, 0);
      check($sformatf("vec%0d imm_src", k), 64'(bus.imm_src), 64'(vecs[k].src));
      check($sformatf("vec%0d illegal", k), 64'(bus.illegal), 64'(vecs[k].ill));
      check($sformatf("vec%0d stall", k), 64'(load_use_stall), 64'(vecs[k].stall));
      check($sformatf("vec%0d id_valid", k), 64'(bus.id_valid), 64'(!vecs[k].stall));
      tick();
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      ins = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             3'($urandom), 5'($urandom), ops[$urandom_range(0, 11)]};
      drive($urandom_range(0, 99) < 70, ins, $urandom,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 40,
            5'($urandom_range(0, 3)), $urandom_range(0, 99) < 70);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
